sc_levelprogressdriver: RTL and testbench

SC_LEVELPROGRESSDRIVER -- requirements
Module: SC_LEVELPROGRESSDRIVER

---
 rtl/sc_levelprogressdriver.sv | 140 ++++++++++++++
 tb/tb_sc_levelprogressdriver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_levelprogressdriver.sv
`timescale 1ns/1ps
// Level progress driver: turns player speed into progress ticks for an
// external progress counter, and sequences levels and game-over.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | after reset, counter disabled, waiting for start
// RUN      | accumulating speed, issuing ticks until level target met
// CLEAR    | single cycle, pulses the counter clear, advances level
// GAMEOVER | all levels done, counter disabled, waiting for start
module sc_levelprogressdriver #(
   parameter logic [23:0] TICK_PERIOD  = 24'd5000000,
   parameter logic [4:0]  LEVEL_TARGET = 5'd20,
   parameter logic [1:0]  NUM_LEVELS   = 2'd3
) (
   input  logic       SC_LEVELPROGRESSDRIVER_CLOCK_50,
   input  logic       SC_LEVELPROGRESSDRIVER_RESET_InHigh,
   input  logic       SC_LEVELPROGRESSDRIVER_Start_InLow,
   input  logic       SC_LEVELPROGRESSDRIVER_Pause_InHigh,
   input  logic [1:0] SC_LEVELPROGRESSDRIVER_Speed_InBus,
   input  logic [4:0] SC_LEVELPROGRESSDRIVER_Progress_InBus,
   output logic       SC_LEVELPROGRESSDRIVER_CountSignal_OutLow,
   output logic       SC_LEVELPROGRESSDRIVER_LevelFinished_OutLow,
   output logic       SC_LEVELPROGRESSDRIVER_GameActive_Out,
   output logic [1:0] SC_LEVELPROGRESSDRIVER_Level_OutBus,
   output logic       SC_LEVELPROGRESSDRIVER_GameOver_Out,
   output logic [1:0] SC_LEVELPROGRESSDRIVER_State_OutBus
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_CLEAR    = 2'd2,
      ST_GAMEOVER = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [24:0] acc_q, acc_d;
   logic [1:0]  level_q, level_d;
   logic        count_n_q, count_n_d;
   logic        lvl_fin_n_q, lvl_fin_n_d;
   logic        active_q, active_d;
   logic        over_q, over_d;

   logic [24:0] acc_sum;
   logic [24:0] tick_period_w;
   logic        speed_ok;
   logic        at_target;
   logic        last_level;

   // Accumulator arithmetic is 25 bits wide so acc+speed never overflows
   // before the compare against the tick period.
   always_comb begin
      tick_period_w = {1'b0, TICK_PERIOD};
      acc_sum       = acc_q + {23'd0, SC_LEVELPROGRESSDRIVER_Speed_InBus};
      speed_ok      = !SC_LEVELPROGRESSDRIVER_Pause_InHigh &&
                      (SC_LEVELPROGRESSDRIVER_Speed_InBus != 2'd0);
      at_target     = (SC_LEVELPROGRESSDRIVER_Progress_InBus >= LEVEL_TARGET);
      last_level    = (level_q == (NUM_LEVELS - 2'd1));
   end

   // Next-state, accumulator, level and pulse decisions; every output is
   // derived from the next state so it appears registered.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      level_d     = level_q;
      count_n_d   = 1'b1;
      lvl_fin_n_d = 1'b1;

      case (state_q)
         ST_IDLE, ST_GAMEOVER: begin
            if (!SC_LEVELPROGRESSDRIVER_Start_InLow) begin
               state_d = ST_RUN;
               level_d = 2'd0;
               acc_d   = '0;
            end
         end
         ST_RUN: begin
            // Target reached: no further ticks so the counter never wraps.
            if (at_target) begin
               state_d     = ST_CLEAR;
               acc_d       = '0;
               lvl_fin_n_d = 1'b0;
            end else if (speed_ok) begin
               if (acc_sum >= tick_period_w) begin
                  acc_d     = acc_sum - tick_period_w;
                  count_n_d = 1'b0;
               end else begin
                  acc_d = acc_sum;
               end
            end
         end
         ST_CLEAR: begin
            acc_d = '0;
            if (last_level) begin
               state_d = ST_GAMEOVER;
            end else begin
               level_d = level_q + 2'd1;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      active_d = (state_d == ST_RUN) || (state_d == ST_CLEAR);
      over_d   = (state_d == ST_GAMEOVER);
   end

   // State and output registers; reset drops any pending pulse at once.
   always_ff @(posedge SC_LEVELPROGRESSDRIVER_CLOCK_50 or posedge SC_LEVELPROGRESSDRIVER_RESET_InHigh) begin
      if (SC_LEVELPROGRESSDRIVER_RESET_InHigh) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         level_q     <= 2'd0;
         count_n_q   <= 1'b1;
         lvl_fin_n_q <= 1'b1;
         active_q    <= 1'b0;
         over_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         level_q     <= level_d;
         count_n_q   <= count_n_d;
         lvl_fin_n_q <= lvl_fin_n_d;
         active_q    <= active_d;
         over_q      <= over_d;
      end
   end

   assign SC_LEVELPROGRESSDRIVER_CountSignal_OutLow   = count_n_q;
   assign SC_LEVELPROGRESSDRIVER_LevelFinished_OutLow = lvl_fin_n_q;
   assign SC_LEVELPROGRESSDRIVER_GameActive_Out       = active_q;
   assign SC_LEVELPROGRESSDRIVER_Level_OutBus         = level_q;
   assign SC_LEVELPROGRESSDRIVER_GameOver_Out         = over_q;
   assign SC_LEVELPROGRESSDRIVER_State_OutBus         = state_q;

endmodule

// File: tb/tb_sc_levelprogressdriver.sv
`timescale 1ns/1ps
// Bench for sc_levelprogressdriver with a progress counter emulated in the
// bench and a cycle-level behavioural model of the level/tick rules.
module tb_sc_levelprogressdriver;

   localparam logic [23:0] TP = 24'd4;
   localparam logic [4:0]  LT = 5'd3;
   localparam logic [1:0]  NL = 2'd2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_n = 1'b1;
   logic       pause = 1'b0;
   logic [1:0] speed = 2'd0;
   logic [4:0] progress = 5'd0;

   logic       cnt_n, fin_n, active, over;
   logic [1:0] level, state;

   int checks = 0;
   int failures = 0;
   int ticks = 0;
   int clears = 0;
   int glitches = 0;

   // model: phase 0 idle, 1 run, 2 clear, 3 gameover
   int m_state, m_acc, m_level, m_cnt_n, m_fin_n, cnt_nxt;

   always #5 clk = ~clk;

   sc_levelprogressdriver #(
      .TICK_PERIOD (TP),
      .LEVEL_TARGET(LT),
      .NUM_LEVELS  (NL)
   ) dut (
      .SC_LEVELPROGRESSDRIVER_CLOCK_50          (clk),
      .SC_LEVELPROGRESSDRIVER_RESET_InHigh      (rst),
      .SC_LEVELPROGRESSDRIVER_Start_InLow       (start_n),
      .SC_LEVELPROGRESSDRIVER_Pause_InHigh      (pause),
      .SC_LEVELPROGRESSDRIVER_Speed_InBus       (speed),
      .SC_LEVELPROGRESSDRIVER_Progress_InBus    (progress),
      .SC_LEVELPROGRESSDRIVER_CountSignal_OutLow  (cnt_n),
      .SC_LEVELPROGRESSDRIVER_LevelFinished_OutLow(fin_n),
      .SC_LEVELPROGRESSDRIVER_GameActive_Out    (active),
      .SC_LEVELPROGRESSDRIVER_Level_OutBus      (level),
      .SC_LEVELPROGRESSDRIVER_GameOver_Out      (over),
      .SC_LEVELPROGRESSDRIVER_State_OutBus      (state)
   );

   // Any falling edge on an active-low output while reset is held is a glitch.
   always @(negedge cnt_n or negedge fin_n) begin
      if (rst) glitches++;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_acc   = 0;
      m_level = 0;
      m_cnt_n = 1;
      m_fin_n = 1;
      cnt_nxt = 0;
   endtask

   // One clock of behaviour, evaluated with the inputs the DUT sampled.
   task automatic model_update();
      int s, nc, nf;
      // counter: cleared while disabled or on clear pulse, else counts ticks
      if (!(m_state == 1 || m_state == 2) || m_fin_n == 0) cnt_nxt = 0;
      else if (m_cnt_n == 0) cnt_nxt = (int'(progress) + 1) % 32;
      else cnt_nxt = int'(progress);
      nc = 1;
      nf = 1;
      if (m_state == 0 || m_state == 3) begin
         if (!start_n) begin
            m_state = 1; m_level = 0; m_acc = 0;
         end
      end else if (m_state == 1) begin
         if (int'(progress) >= int'(LT)) begin
            m_state = 2; m_acc = 0; nf = 0;
         end else if (!pause && speed != 2'd0) begin
            s = m_acc + int'(speed);
            if (s >= int'(TP)) begin
               m_acc = s - int'(TP); nc = 0;
            end else begin
               m_acc = s;
            end
         end
      end else begin
         m_acc = 0;
         if (m_level == int'(NL) - 1) m_state = 3;
         else begin
            m_level = m_level + 1; m_state = 1;
         end
      end
      m_cnt_n = nc;
      m_fin_n = nf;
   endtask

   task automatic compare();
      chk("state", int'(state), m_state);
      chk("level", int'(level), m_level);
      chk("count_n", int'(cnt_n), m_cnt_n);
      chk("finished_n", int'(fin_n), m_fin_n);
      chk("game_active", int'(active), int'(m_state == 1 || m_state == 2));
      chk("game_over", int'(over), int'(m_state == 3));
      chk("pulse_overlap", int'(!cnt_n && !fin_n), 0);
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else model_update();
      @(negedge clk);
      progress = 5'(cnt_nxt);
      compare();
      if (!cnt_n) ticks++;
      if (!fin_n) clears++;
   endtask

   task automatic assert_reset_now();
      rst = 1'b1;
      #1;
      model_reset();
      compare();
   endtask

   initial begin
      model_reset();
      #2;
      rst = 1'b1;
      step();
      step();
      chk("rst_state", int'(state), 0);
      chk("rst_count_n", int'(cnt_n), 1);
      chk("rst_active", int'(active), 0);
      rst = 1'b0;

      // level 0 at speed 1: one tick every 4 cycles
      speed = 2'd1;
      start_n = 1'b0;
      step();
      chk("start_state", int'(state), 1);
      chk("start_level", int'(level), 0);
      start_n = 1'b1;
      ticks = 0;
      clears = 0;
      repeat (12) step();
      chk("l0_ticks", ticks, 3);
      step();
      chk("progress_at_target", int'(progress), 3);
      chk("pre_clear_state", int'(state), 1);
      step();
      chk("clear_state", int'(state), 2);
      chk("clear_fin_n", int'(fin_n), 0);
      chk("clear_no_tick", int'(cnt_n), 1);
      step();
      chk("l1_state", int'(state), 1);
      chk("l1_level", int'(level), 1);
      chk("progress_cleared", int'(progress), 0);
      chk("clears_once", clears, 1);

      // level 1 at speed 3: three ticks in the first five cycles
      speed = 2'd3;
      ticks = 0;
      repeat (5) step();
      chk("l1_ticks", ticks, 3);
      step();
      chk("l1_clear_state", int'(state), 2);
      step();
      chk("gameover_state", int'(state), 3);
      chk("gameover_flag", int'(over), 1);
      chk("gameover_active", int'(active), 0);
      chk("gameover_level", int'(level), 1);
      repeat (2) step();
      start_n = 1'b0;
      step();
      chk("restart_state", int'(state), 1);
      chk("restart_level", int'(level), 0);
      start_n = 1'b1;

      // pause at acc=2 for 10 cycles, then resume
      speed = 2'd1;
      repeat (2) step();
      pause = 1'b1;
      ticks = 0;
      repeat (10) step();
      chk("pause_ticks", ticks, 0);
      pause = 1'b0;
      step();
      chk("resume_first", int'(cnt_n), 1);
      step();
      chk("resume_tick", int'(cnt_n), 0);

      // reset the cycle a tick is due
      repeat (3) step();
      assert_reset_now();
      chk("rst_imm_state", int'(state), 0);
      chk("rst_imm_count_n", int'(cnt_n), 1);
      step();
      chk("rst_no_tick", int'(cnt_n), 1);
      rst = 1'b0;

      // randomized play
      for (int i = 0; i < 3000; i++) begin
         speed   = 2'($urandom_range(0, 3));
         pause   = ($urandom_range(0, 3) == 0);
         start_n = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 299) == 0) begin
            assert_reset_now();
            step();
            rst = 1'b0;
         end
         step();
      end

      chk("reset_glitches", glitches, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
